serial_xor_checker: RTL and testbench

SERIAL_XOR_CHECKER -- requirements
Module: serial_xor_checker

---
 rtl/serial_xor_checker.sv | 115 +++++++++++
 tb/tb_serial_xor_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_xor_checker.sv
// Compares two serial bit streams over an N-bit frame and reports the mismatch count, parity and equality.
// Optional: define FIRST_MISMATCH_EN to add first_vld/first_idx, the index of the first differing bit.
`timescale 1ns/1ps
module serial_xor_checker #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic          a,
  input  logic          b,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic          diff,
  output logic          parity,
  output logic [CW-1:0] mism_cnt,
  output logic          equal
`ifdef FIRST_MISMATCH_EN
  ,
  output logic          first_vld,
  output logic [7:0]    first_idx
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [7:0]    LAST_IDX = 8'(N - 1);

  state_t        r_state;
  logic [7:0]    r_bit_cnt;
  logic          r_diff;
  logic          r_parity;
  logic [CW-1:0] r_mism_cnt;
  logic          w_accept;
  logic          w_x;
  logic          w_last;

`ifdef FIRST_MISMATCH_EN
  logic          r_first_vld;
  logic [7:0]    r_first_idx;
`endif

  assign w_accept = in_valid && (r_state == RUN);
  assign w_x      = (~a) ^ (~b);
  assign w_last   = (r_bit_cnt == LAST_IDX);

  // NOTE: every register below uses <= so each one sees the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_diff     <= 1'b0;
      r_parity   <= 1'b0;
      r_mism_cnt <= '0;
`ifdef FIRST_MISMATCH_EN
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= RUN;
            r_bit_cnt  <= '0;
            r_diff     <= 1'b0;
            r_parity   <= 1'b0;
            r_mism_cnt <= '0;
`ifdef FIRST_MISMATCH_EN
            r_first_vld <= 1'b0;
            r_first_idx <= '0;
`endif
          end
        end
        RUN: begin
          if (w_accept) begin
            r_bit_cnt <= r_bit_cnt + 8'd1;
            r_diff    <= w_x;
            r_parity  <= r_parity ^ w_x;
            // Saturate rather than wrap so a long mismatching frame never reads as equal.
            if (w_x && (r_mism_cnt != CNT_MAX))
              r_mism_cnt <= r_mism_cnt + CW'(1);
`ifdef FIRST_MISMATCH_EN
            if (w_x && !r_first_vld) begin
              r_first_vld <= 1'b1;
              r_first_idx <= r_bit_cnt;
            end
`endif
            if (w_last)
              r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready = (r_state == RUN);
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign diff     = r_diff;
  assign parity   = r_parity;
  assign mism_cnt = r_mism_cnt;
  assign equal    = (r_mism_cnt == '0);

`ifdef FIRST_MISMATCH_EN
  assign first_vld = r_first_vld;
  assign first_idx = r_first_idx;
`endif

endmodule

// File: tb/tb_serial_xor_checker.sv
// Randomised self-checking bench for serial_xor_checker against a frame-level reference model.
// Build with +define+FIRST_MISMATCH_EN to also check first_vld/first_idx.
`timescale 1ns/1ps
module tb_serial_xor_checker;
  localparam int N   = 8;
  localparam int CW  = 8;
  localparam int N2  = 20;
  localparam int CW2 = 4;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0;
  logic in_valid = 1'b0, a = 1'b0, b = 1'b0;
  logic in_ready, busy, done, diff, parity, equal;
  logic [CW-1:0] mism_cnt;
  logic in_ready2, busy2, done2, diff2, parity2, equal2;
  logic [CW2-1:0] mism_cnt2;
`ifdef FIRST_MISMATCH_EN
  logic first_vld, first_vld2;
  logic [7:0] first_idx, first_idx2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_xor_checker #(.N(N), .CW(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .a(a), .b(b),
    .in_ready(in_ready), .busy(busy), .done(done), .diff(diff), .parity(parity),
    .mism_cnt(mism_cnt), .equal(equal)
`ifdef FIRST_MISMATCH_EN
    , .first_vld(first_vld), .first_idx(first_idx)
`endif
  );

  serial_xor_checker #(.N(N2), .CW(CW2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .a(a), .b(b),
    .in_ready(in_ready2), .busy(busy2), .done(done2), .diff(diff2), .parity(parity2),
    .mism_cnt(mism_cnt2), .equal(equal2)
`ifdef FIRST_MISMATCH_EN
    , .first_vld(first_vld2), .first_idx(first_idx2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Frame result from the list of per-bit mismatch flags.
  function automatic void ref_frame(input bit q[$], input int cw, output int cnt, output int par,
                                    output int last, output int fidx, output int fv);
    int ones = 0;
    fv = 0;
    fidx = 0;
    foreach (q[i]) begin
      if (q[i]) begin
        ones++;
        if (fv == 0) begin
          fv = 1;
          fidx = i;
        end
      end
    end
    cnt  = (ones > (1 << cw) - 1) ? (1 << cw) - 1 : ones;
    par  = ones % 2;
    last = (q.size() > 0) ? int'(q[q.size()-1]) : 0;
  endfunction

  task automatic check_results(input string tag, input int m, input int p, input int l,
                               input int fi, input int fv);
    check({tag, "_mism"}, 32'(mism_cnt), m);
    check({tag, "_parity"}, 32'(parity), p);
    check({tag, "_diff"}, 32'(diff), l);
    check({tag, "_equal"}, 32'(equal), (m == 0) ? 1 : 0);
`ifdef FIRST_MISMATCH_EN
    check({tag, "_first_vld"}, 32'(first_vld), fv);
    if (fv != 0) check({tag, "_first_idx"}, 32'(first_idx), fi);
`else
    if (fv < 0 || fi < 0) check({tag, "_first_neg"}, 0, 1);
`endif
  endtask

  // mode 0: in_valid always high, 1: low every other cycle (low first), 2: random.
  task automatic run_frame(input logic [N-1:0] va, input logic [N-1:0] vb, input int mode,
                           input bit hold, input string tag);
    bit q[$];
    int k = 0, cyc = 0, m, p, l, fi, fv;
    bit v;
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_busy_start"}, 32'(busy), 1);
    @(negedge clk);
    if (!hold) start = 1'b0;
    while (1) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = ((cyc % 2) == 1);
        default: v = 1'($urandom_range(0, 1));
      endcase
      check({tag, "_in_ready"}, 32'(in_ready), 1);
      in_valid = v;
      a = v ? va[k] : 1'($urandom);
      b = v ? vb[k] : 1'($urandom);
      if (v) q.push_back(va[k] ^ vb[k]);
      @(posedge clk); #1;
      cyc++;
      if (v) k++;
      if (k == N || cyc >= 200) break;
      check({tag, "_early_done"}, 32'(done), 0);
      @(negedge clk);
    end
    if (k < N) check({tag, "_timeout"}, 32'(k), N);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy_done"}, 32'(busy), 1);
    check({tag, "_ready_done"}, 32'(in_ready), 0);
    if (mode < 2) check({tag, "_latency"}, 32'(cyc), (mode == 0) ? N : 2 * N);
    ref_frame(q, CW, m, p, l, fi, fv);
    check_results(tag, m, p, l, fi, fv);

    @(negedge clk);
    in_valid = 1'($urandom);
    a = 1'($urandom);
    b = 1'($urandom);
    start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_idle_busy"}, 32'(busy), 0);
    if (hold) begin
      @(posedge clk); #1;
      check({tag, "_restart"}, 32'(busy), 1);
      @(negedge clk);
      start = 1'b0;
      for (int j = 0; j < N; j++) begin
        in_valid = 1'b1;
        a = 1'b1;
        b = 1'b1;
        @(negedge clk);
      end
      check({tag, "_restart_done"}, 32'(done), 1);
      check_results({tag, "_restart"}, 0, 0, 0, 0, 0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      check({tag, "_restart_idle"}, 32'(busy), 0);
    end else begin
      @(negedge clk);
      start = 1'b0;
      for (int j = 0; j < 3; j++) begin
        in_valid = 1'($urandom);
        a = 1'($urandom);
        b = 1'($urandom);
        @(posedge clk); #1;
        check({tag, "_hold_busy"}, 32'(busy), 0);
        @(negedge clk);
      end
      check_results({tag, "_hold"}, m, p, l, fi, fv);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_ready"}, 32'(in_ready), 0);
    check({tag, "_done"}, 32'(done), 0);
    check_results(tag, 0, 0, 0, 0, 0);
  endtask

  task automatic run_sat();
    bit q[$];
    int k = 0, cyc = 0, m, p, l, fi, fv;
    bit v, x, aa;
    @(negedge clk);
    start2 = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start2 = 1'b0;
    while (1) begin
      v  = 1'($urandom_range(0, 1));
      x  = (k < 16) ? 1'b1 : 1'($urandom);
      aa = 1'($urandom);
      in_valid = v;
      a = aa;
      b = aa ^ x;
      if (v) q.push_back(x);
      @(posedge clk); #1;
      cyc++;
      if (v) k++;
      if (k == N2 || cyc >= 400) break;
      @(negedge clk);
    end
    if (k < N2) check("sat_timeout", 32'(k), N2);
    ref_frame(q, CW2, m, p, l, fi, fv);
    check("sat_done", 32'(done2), 1);
    check("sat_mism", 32'(mism_cnt2), m);
    check("sat_parity", 32'(parity2), p);
    check("sat_diff", 32'(diff2), l);
    check("sat_equal", 32'(equal2), 0);
    check("sat_main_idle", 32'(busy), 0);
`ifdef FIRST_MISMATCH_EN
    check("sat_first_idx", 32'(first_idx2), fi);
`endif
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] va, vb;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(8'b10110010, 8'b10110010, 0, 1'b0, "same");
    run_frame(8'b00000000, 8'b11111111, 0, 1'b0, "all_diff");
    run_frame(8'b10110010, 8'b10111010, 0, 1'b0, "bit3");
    run_frame(8'b00000000, 8'b11111111, 1, 1'b0, "gappy");

    // Abort a frame with an asynchronous reset after four accepted mismatching pairs.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a = 1'b0;
      b = 1'b1;
      @(negedge clk);
    end
    check("pre_reset_mism", 32'(mism_cnt), 4);
    #2 rst_n = 1'b0;
    #1;
    check_reset("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_busy", 32'(busy), 0);
    check("release_mism", 32'(mism_cnt), 0);
    @(negedge clk);
    in_valid = 1'b0;
    run_frame(8'b01010101, 8'b00110011, 0, 1'b0, "after_reset");

    run_frame(8'b11001010, 8'b01101011, 0, 1'b1, "start_held");

    for (int i = 0; i < 6; i++) begin
      va = N'($urandom);
      vb = va ^ (N'($urandom) & N'($urandom));
      run_frame(va, vb, 2, 1'b0, $sformatf("rand%0d", i));
    end

    run_sat();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
